// File: rtl/stoplight_ctrl_pkg.sv
// Shared types and lamp encodings for the Washington / Prospect stoplight.
`timescale 1ns/100ps
package stoplight_ctrl_pkg;

    // Controller phases. Names carry an S_ prefix so they cannot collide
    // with the dwell-length parameters of the controller (e.g. PROS_GRN).
    typedef enum logic [1:0] {
        S_WASH_GRN = 2'd0,
        S_WASH_YLW = 2'd1,
        S_PROS_GRN = 2'd2,
        S_PROS_YLW = 2'd3
    } state_t;

    // One-hot lamp encodings, {G,Y,R}.
    localparam logic [2:0] GRN = 3'b100;
    localparam logic [2:0] YLW = 3'b010;
    localparam logic [2:0] RED = 3'b001;

    // Lamp pattern for a phase, packed as {wash, pros}.
    // Unknown encodings show the resting pattern, matching the recovery target.
    function automatic logic [5:0] lamps(input state_t s);
        logic [5:0] l;
        l = {GRN, RED};
        case (s)
            S_WASH_GRN: l = {GRN, RED};
            S_WASH_YLW: l = {YLW, RED};
            S_PROS_GRN: l = {RED, GRN};
            S_PROS_YLW: l = {RED, YLW};
            default:    l = {GRN, RED};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/stoplight_ctrl.sv
// Two-road stoplight controller. Washington rests green and yields to a
// Prospect car only after its minimum green; Prospect gets a fixed green.
// Lamps are registered from the next phase, so they always equal the decode
// of the state register and never follow car_present combinationally.
`timescale 1ns/100ps
module stoplight_ctrl
    import stoplight_ctrl_pkg::*;
#(
    parameter int WASH_MIN_GRN = 4,
    parameter int PROS_GRN     = 4,
    parameter int YLW_CYC      = 1,
    parameter int CNT_W        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car_present,
    output logic [2:0] light_pros,
    output logic [2:0] light_wash
);

    // Last dwell count of each phase; leaving is allowed once cnt reaches it.
    localparam logic [CNT_W-1:0] WASH_LAST = CNT_W'(WASH_MIN_GRN - 1);
    localparam logic [CNT_W-1:0] PROS_LAST = CNT_W'(PROS_GRN - 1);
    localparam logic [CNT_W-1:0] YLW_LAST  = CNT_W'(YLW_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;

    // Next-phase selection; only the Washington green looks at the sensor,
    // and the request is not remembered if the car leaves early.
    always_comb begin
        state_nxt = state;
        case (state)
            S_WASH_GRN: if (car_present && (cnt >= WASH_LAST)) state_nxt = S_WASH_YLW;
            S_WASH_YLW: if (cnt >= YLW_LAST)  state_nxt = S_PROS_GRN;
            S_PROS_GRN: if (cnt >= PROS_LAST) state_nxt = S_PROS_YLW;
            S_PROS_YLW: if (cnt >= YLW_LAST)  state_nxt = S_WASH_GRN;
            default:    state_nxt = S_WASH_GRN;
        endcase
    end

    // Phase register, saturating dwell counter and registered lamp outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_WASH_GRN;
            cnt        <= '0;
            light_wash <= GRN;
            light_pros <= RED;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            {light_wash, light_pros} <= lamps(state_nxt);
        end
    end

endmodule

// File: tb/tb_stoplight_ctrl.sv
// Bench for stoplight_ctrl: per-cycle expected lamp patterns are queued as
// stimulus is driven and compared after each rising edge.
`timescale 1ns/100ps
module tb_stoplight_ctrl;
    import stoplight_ctrl_pkg::*;

    logic       clk = 1'b1;
    logic       rst = 1'b1;
    logic       car_present = 1'b0;
    logic [2:0] light_pros;
    logic [2:0] light_wash;

    int total = 0;
    int bad   = 0;
    logic [5:0] exp_q[$];

    // Clock: period 5, rising edges at 5, 10, 15, ...
    always #2.5 clk = ~clk;

    stoplight_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .car_present (car_present),
        .light_pros  (light_pros),
        .light_wash  (light_wash)
    );

    // Lamp invariants on every falling edge while out of reset.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            total++;
            if (!$onehot(light_wash) || !$onehot(light_pros) ||
                (light_wash !== RED && light_pros !== RED)) begin
                bad++;
                $display("FAIL invariant @%0t: wash=%b pros=%b, want one-hot and one road RED",
                         $time, light_wash, light_pros);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Drive the sensor for the next edge, queue the expected lamps, and
    // advance to 1 time unit after that edge.
    task automatic drive(input logic car, input logic [2:0] ew, input logic [2:0] ep);
        car_present = car;
        exp_q.push_back({ew, ep});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] e;
        #1 rst = 1'b0;
        #1;
        total++;
        if ({light_wash, light_pros} !== {GRN, RED}) begin
            bad++;
            $display("FAIL reset_value: wash=%b pros=%b, want wash=%b pros=%b",
                     light_wash, light_pros, GRN, RED);
        end
        #4 rst = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, GRN, RED);
            e = exp_q.pop_front();
            total++;
            if ({light_wash, light_pros} !== e) begin
                bad++;
                $display("FAIL idle_%0d: wash=%b pros=%b, want wash=%b pros=%b",
                         i, light_wash, light_pros, e[5:3], e[2:0]);
            end
        end
    endtask

    task automatic test_service();
        logic       car [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0] ew  [5] = '{YLW, RED, RED, RED, RED};
        logic [2:0] ep  [5] = '{RED, GRN, GRN, GRN, GRN};
        logic [5:0] e;
        for (int i = 0; i < 5; i++) begin
            drive(car[i], ew[i], ep[i]);
            e = exp_q.pop_front();
            total++;
            if ({light_wash, light_pros} !== e) begin
                bad++;
                $display("FAIL service_%0d: wash=%b pros=%b, want wash=%b pros=%b",
                         i, light_wash, light_pros, e[5:3], e[2:0]);
            end
        end
    endtask

    task automatic test_pros_timing();
        logic [2:0] ew [2] = '{RED, GRN};
        logic [2:0] ep [2] = '{YLW, RED};
        logic [5:0] e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ew[i], ep[i]);
            e = exp_q.pop_front();
            total++;
            if ({light_wash, light_pros} !== e) begin
                bad++;
                $display("FAIL pros_timing_%0d: wash=%b pros=%b, want wash=%b pros=%b",
                         i, light_wash, light_pros, e[5:3], e[2:0]);
            end
        end
    endtask

    task automatic test_min_green();
        logic       car [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0] ew  [8] = '{GRN, GRN, GRN, GRN, GRN, GRN, YLW, RED};
        logic [2:0] ep  [8] = '{RED, RED, RED, RED, RED, RED, RED, GRN};
        logic [5:0] e;
        for (int i = 0; i < 8; i++) begin
            drive(car[i], ew[i], ep[i]);
            e = exp_q.pop_front();
            total++;
            if ({light_wash, light_pros} !== e) begin
                bad++;
                $display("FAIL min_green_%0d: wash=%b pros=%b, want wash=%b pros=%b",
                         i, light_wash, light_pros, e[5:3], e[2:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] e;
        #1 rst = 1'b0;
        #1;
        total++;
        if ({light_wash, light_pros} !== {GRN, RED}) begin
            bad++;
            $display("FAIL async_reset: wash=%b pros=%b, want wash=%b pros=%b",
                     light_wash, light_pros, GRN, RED);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, GRN, RED);
            e = exp_q.pop_front();
            total++;
            if ({light_wash, light_pros} !== e) begin
                bad++;
                $display("FAIL reset_hold_%0d: wash=%b pros=%b, want wash=%b pros=%b",
                         i, light_wash, light_pros, e[5:3], e[2:0]);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [2:0] ew [10] = '{GRN, GRN, GRN, YLW, RED, RED, RED, RED, RED, GRN};
        logic [2:0] ep [10] = '{RED, RED, RED, RED, GRN, GRN, GRN, GRN, YLW, RED};
        logic [5:0] e;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) begin
                drive(1'b1, ew[i], ep[i]);
                e = exp_q.pop_front();
                total++;
                if ({light_wash, light_pros} !== e) begin
                    bad++;
                    $display("FAIL back_to_back_%0d_%0d: wash=%b pros=%b, want wash=%b pros=%b",
                             r, i, light_wash, light_pros, e[5:3], e[2:0]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [5:0] e;
        int n;
        n = $urandom_range(8, 12);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, GRN, RED);
            e = exp_q.pop_front();
            total++;
            if ({light_wash, light_pros} !== e) begin
                bad++;
                $display("FAIL sat_idle_%0d: wash=%b pros=%b, want wash=%b pros=%b",
                         i, light_wash, light_pros, e[5:3], e[2:0]);
            end
        end
        drive(1'b1, YLW, RED);
        e = exp_q.pop_front();
        total++;
        if ({light_wash, light_pros} !== e) begin
            bad++;
            $display("FAIL sat_yield: wash=%b pros=%b, want wash=%b pros=%b",
                     light_wash, light_pros, e[5:3], e[2:0]);
        end
        drive(1'b0, RED, GRN);
        e = exp_q.pop_front();
        total++;
        if ({light_wash, light_pros} !== e) begin
            bad++;
            $display("FAIL sat_pros: wash=%b pros=%b, want wash=%b pros=%b",
                     light_wash, light_pros, e[5:3], e[2:0]);
        end
    endtask

    initial begin
        test_reset();
        test_service();
        test_pros_timing();
        test_min_green();
        test_async_reset();
        test_back_to_back();
        test_saturation();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: %0d left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
